// File: rtl/dmem_pkg.sv
// Shared types and address offsets for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        RAM,
        LED,
        SW,
        BAD
    } region_e;

    localparam logic [31:0] LED_OFS = 32'd0;
    localparam logic [31:0] SW_OFS  = 32'd4;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the core and the data-memory responder.
interface dmem_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (output req, we, addr, wdata, input rdata, ready, err);
    modport slave  (input req, we, addr, wdata, output rdata, ready, err);

endinterface

// File: rtl/dmem_responder_sync2.sv
// Purpose: two-flop synchronizer for asynchronous board inputs.
// Latency: two clk edges from d to q.
// Backpressure: none; free-running sampler.
module sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: word RAM plus LED/switch I/O window behind a req/ready load-store bus.
// Latency: ready pulses WAIT_CYCLES+1 cycles after req is first seen in IDLE.
// Backpressure: requester holds req until ready; dropping req during WAIT aborts.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
    input  logic                clk,
    input  logic                reset,
    dmem_responder_if.slave     bus,
    output logic [15:0]         led_out,
    input  logic [15:0]         sw_in
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] LED_ADDR  = IO_BASE + LED_OFS;
    localparam logic [31:0] SW_ADDR   = IO_BASE + SW_OFS;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    function automatic region_e decode(input logic [31:0] a);
        if (a[1:0] != 2'b00)   return BAD;
        else if (a == LED_ADDR) return LED;
        else if (a == SW_ADDR)  return SW;
        else if (a < RAM_BYTES) return RAM;
        else                    return BAD;
    endfunction

    state_e      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [15:0] sw_sync;
    logic [31:0] ram [DEPTH_WORDS];

    // With zero wait states RESP is entered on the accepting edge, so the
    // response must be built from the live bus rather than the latched copy.
    logic [31:0] cur_addr;
    logic        cur_we;
    region_e     cur_region;
    region_e     resp_region;
    logic [31:0] cur_rdata;

    sync2 #(.WIDTH(16)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_in),
        .q     (sw_sync)
    );

    always_comb begin
        cur_addr    = (state == IDLE) ? bus.addr : addr_q;
        cur_we      = (state == IDLE) ? bus.we   : we_q;
        cur_region  = decode(cur_addr);
        resp_region = decode(addr_q);
        cur_rdata   = 32'd0;
        case (cur_region)
            RAM:     cur_rdata = ram[cur_addr[AW+1:2]];
            LED:     cur_rdata = {16'd0, led_out};
            SW:      cur_rdata = {16'd0, sw_sync};
            default: cur_rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.req) begin
                cnt_nx   = WAIT_INIT;
                state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: if (!bus.req) begin
                state_nx = IDLE;
            end else begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            we_q      <= 1'b0;
            bus.rdata <= 32'd0;
            bus.err   <= 1'b0;
            led_out   <= 16'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && bus.req) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                we_q    <= bus.we;
            end
            if (state == RESP) begin
                bus.rdata <= 32'd0;
                bus.err   <= 1'b0;
                if (we_q && resp_region == LED) led_out <= wdata_q[15:0];
            end else if (state_nx == RESP) begin
                bus.rdata <= cur_we ? 32'd0 : cur_rdata;
                bus.err   <= (cur_region == BAD);
            end
        end
    end

    // RAM has no reset; an asserted reset forces IDLE, which blocks the commit.
    always_ff @(posedge clk) begin
        if (state == RESP && we_q && resp_region == RAM)
            ram[addr_q[AW+1:2]] <= wdata_q;
    end

    assign bus.ready = (state == RESP);

endmodule
